// File: rtl/pc_alu_pkg.sv
// pc_alu_pkg: shared encodings and default widths for the PC/ALU datapath slice.
//   ALU_OP_*  : 4-bit ALU operation codes (0xC-0xF are undefined and yield 0)
//   PC_SRC_*  : 2-bit next-PC mux selects
//   PC_ALU_*  : default DATA_W / ADDR_W / RESET_VECTOR values
package pc_alu_pkg;

    localparam int unsigned PC_ALU_DATA_W       = 64;
    localparam int unsigned PC_ALU_ADDR_W       = 10;
    localparam int unsigned PC_ALU_RESET_VECTOR = 512;

    localparam logic [3:0] ALU_OP_AND    = 4'h0;
    localparam logic [3:0] ALU_OP_OR     = 4'h1;
    localparam logic [3:0] ALU_OP_ADD    = 4'h2;
    localparam logic [3:0] ALU_OP_XOR    = 4'h3;
    localparam logic [3:0] ALU_OP_SLL    = 4'h4;
    localparam logic [3:0] ALU_OP_SRL    = 4'h5;
    localparam logic [3:0] ALU_OP_SUB    = 4'h6;
    localparam logic [3:0] ALU_OP_SLT    = 4'h7;
    localparam logic [3:0] ALU_OP_SRA    = 4'h8;
    localparam logic [3:0] ALU_OP_NOR    = 4'h9;
    localparam logic [3:0] ALU_OP_SLTU   = 4'hA;
    localparam logic [3:0] ALU_OP_PASS_B = 4'hB;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RESET  = 2'd3;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU, zero cycle latency.
// Optional feature macro: ALU_OVF_EN (adds alu_overflow output).
// Ports:
//   alu_op       in   4       operation code (pc_alu_pkg::ALU_OP_*)
//   src_a        in   DATA_W  operand A (also the shifted value)
//   src_b        in   DATA_W  operand B (low log2(DATA_W) bits are the shift amount)
//   alu_result   out  DATA_W  result
//   alu_zero     out  1       result == 0
//   alu_overflow out  1       signed overflow for ADD/SUB only (ALU_OVF_EN)
module alu_core
    import pc_alu_pkg::*;
#(
    parameter int unsigned DATA_W = PC_ALU_DATA_W
) (
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero
`ifdef ALU_OVF_EN
    ,
    output logic              alu_overflow
`endif
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;

    assign shamt = src_b[SHAMT_W-1:0];
    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_OP_AND:    alu_result = src_a & src_b;
            ALU_OP_OR:     alu_result = src_a | src_b;
            ALU_OP_ADD:    alu_result = sum;
            ALU_OP_XOR:    alu_result = src_a ^ src_b;
            ALU_OP_SLL:    alu_result = src_a << shamt;
            ALU_OP_SRL:    alu_result = src_a >> shamt;
            ALU_OP_SUB:    alu_result = diff;
            ALU_OP_SLT:    alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_OP_SRA:    alu_result = $signed(src_a) >>> shamt;
            ALU_OP_NOR:    alu_result = ~(src_a | src_b);
            ALU_OP_SLTU:   alu_result = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            ALU_OP_PASS_B: alu_result = src_b;
            default:       alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

`ifdef ALU_OVF_EN
    // Signed overflow: ADD overflows when operands share a sign that the sum lacks;
    // SUB when operand signs differ and the difference takes B's sign.
    always_comb begin
        alu_overflow = 1'b0;
        case (alu_op)
            ALU_OP_ADD: alu_overflow = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                                       (sum[DATA_W-1] != src_a[DATA_W-1]);
            ALU_OP_SUB: alu_overflow = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                                       (diff[DATA_W-1] != src_a[DATA_W-1]);
            default:    alu_overflow = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/pc_alu_unit.sv
// pc_alu_unit: PC update path and main ALU of the multi-cycle datapath.
// Optional feature macro: ALU_OVF_EN (adds alu_overflow output).
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       async active-high, forces pc to RESET_VECTOR
//   pc_write     in   1       PC load enable
//   pc_src       in   2       next-PC select (PC_SRC_*)
//   alu_op       in   4       ALU operation (ALU_OP_*)
//   src_a/src_b  in   DATA_W  ALU operands
//   alu_out_reg  in   ADDR_W  registered ALU result (branch target)
//   jump_addr    in   ADDR_W  jump target
//   pc           out  ADDR_W  registered PC
//   pc_next      out  ADDR_W  combinational next-PC mux output
//   alu_result   out  DATA_W  combinational ALU result
//   alu_zero     out  1       alu_result == 0
//   alu_overflow out  1       signed ADD/SUB overflow (ALU_OVF_EN)
module pc_alu_unit
    import pc_alu_pkg::*;
#(
    parameter int unsigned DATA_W       = PC_ALU_DATA_W,
    parameter int unsigned ADDR_W       = PC_ALU_ADDR_W,
    parameter int unsigned RESET_VECTOR = PC_ALU_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic [1:0]        pc_src,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [ADDR_W-1:0] alu_out_reg,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_zero
`ifdef ALU_OVF_EN
    ,
    output logic              alu_overflow
`endif
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .alu_op       (alu_op),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
`ifdef ALU_OVF_EN
        ,
        .alu_overflow (alu_overflow)
`endif
    );

    // ALU result is truncated to the PC width, so PC arithmetic wraps.
    always_comb begin
        pc_next = RESET_PC;
        case (pc_src)
            PC_SRC_ALU:    pc_next = alu_result[ADDR_W-1:0];
            PC_SRC_ALUOUT: pc_next = alu_out_reg;
            PC_SRC_JUMP:   pc_next = jump_addr;
            PC_SRC_RESET:  pc_next = RESET_PC;
            default:       pc_next = RESET_PC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_write) begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_alu_unit.sv
// tb_pc_alu_unit: directed self-checking bench for pc_alu_unit.
// Build with +define+ALU_OVF_EN to also exercise the overflow output.
module tb_pc_alu_unit;
    import pc_alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_op;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [9:0]  alu_out_reg;
    logic [9:0]  jump_addr;
    logic [9:0]  pc;
    logic [9:0]  pc_next;
    logic [63:0] alu_result;
    logic        alu_zero;
`ifdef ALU_OVF_EN
    logic        alu_overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_alu_unit #(
        .DATA_W       (64),
        .ADDR_W       (10),
        .RESET_VECTOR (512)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_out_reg  (alu_out_reg),
        .jump_addr    (jump_addr),
        .pc           (pc),
        .pc_next      (pc_next),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
`ifdef ALU_OVF_EN
        ,
        .alu_overflow (alu_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_res);
        alu_op = op;
        src_a  = a;
        src_b  = b;
        #1;
        check(tag, alu_result, exp_res);
        check({tag, "_zero"}, {63'd0, alu_zero}, {63'd0, exp_res == 64'd0});
    endtask

    localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

    initial begin
        reset       = 1'b1;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_ALU;
        alu_op      = ALU_OP_ADD;
        src_a       = '0;
        src_b       = '0;
        alu_out_reg = '0;
        jump_addr   = '0;
        #2;
        check("reset_pc", {54'd0, pc}, 64'd512);

        // Move pc to 0x05C, then assert reset mid-cycle.
        reset     = 1'b0;
        pc_src    = PC_SRC_JUMP;
        jump_addr = 10'h05C;
        pc_write  = 1'b1;
        tick();
        check("jump_5c", {54'd0, pc}, 64'h05C);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", {54'd0, pc}, 64'd512);
        tick();
        check("reset_hold1", {54'd0, pc}, 64'd512);
        tick();
        check("reset_hold2", {54'd0, pc}, 64'd512);

        // Fetch increment; first enabled edge after release loads pc_next.
        reset  = 1'b0;
        pc_src = PC_SRC_ALU;
        alu_op = ALU_OP_ADD;
        src_a  = 64'd512;
        src_b  = 64'd4;
        #1;
        check("fetch_result", alu_result, 64'd516);
        check("fetch_pc_next", {54'd0, pc_next}, 64'd516);
        tick();
        check("fetch_pc", {54'd0, pc}, 64'd516);
        check("fetch_zero", {63'd0, alu_zero}, 64'd0);
        pc_write = 1'b0;
        tick();
        check("pc_hold", {54'd0, pc}, 64'd516);

        // Branch compare and target.
        alu_op = ALU_OP_SUB;
        src_a  = 64'h1234;
        src_b  = 64'h1234;
        #1;
        check("sub_result", alu_result, 64'd0);
        check("sub_zero", {63'd0, alu_zero}, 64'd1);
        pc_src      = PC_SRC_ALUOUT;
        alu_out_reg = 10'd600;
        pc_write    = 1'b1;
        tick();
        check("branch_pc", {54'd0, pc}, 64'd600);

        // Remaining mux sources and wrap.
        pc_src    = PC_SRC_JUMP;
        jump_addr = 10'd700;
        tick();
        check("jump_pc", {54'd0, pc}, 64'd700);
        pc_src = PC_SRC_RESET;
        tick();
        check("vector_pc", {54'd0, pc}, 64'd512);
        pc_src = PC_SRC_ALU;
        alu_op = ALU_OP_ADD;
        src_a  = 64'd1020;
        src_b  = 64'd4;
        #1;
        check("wrap_result", alu_result, 64'd1024);
        check("wrap_pc_next", {54'd0, pc_next}, 64'd0);
        tick();
        check("wrap_pc", {54'd0, pc}, 64'd0);
        pc_write = 1'b0;

        // ALU sweep with a = -8, b = 3.
        alu_vec("and",    ALU_OP_AND,    NEG8, 64'd3, 64'd0);
        alu_vec("or",     ALU_OP_OR,     NEG8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        alu_vec("xor",    ALU_OP_XOR,    NEG8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        alu_vec("slt",    ALU_OP_SLT,    NEG8, 64'd3, 64'd1);
        alu_vec("sltu",   ALU_OP_SLTU,   NEG8, 64'd3, 64'd0);
        alu_vec("sra",    ALU_OP_SRA,    NEG8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_vec("srl",    ALU_OP_SRL,    NEG8, 64'd3, 64'h1FFF_FFFF_FFFF_FFFF);
        alu_vec("sll",    ALU_OP_SLL,    NEG8, 64'd3, 64'hFFFF_FFFF_FFFF_FFC0);
        alu_vec("nor",    ALU_OP_NOR,    NEG8, 64'd3, 64'd4);
        alu_vec("pass_b", ALU_OP_PASS_B, NEG8, 64'd3, 64'd3);
        alu_vec("op_c",   4'hC,          NEG8, 64'd3, 64'd0);
        alu_vec("op_f",   4'hF,          NEG8, 64'd3, 64'd0);
        alu_vec("sub_neg", ALU_OP_SUB,   NEG8, 64'd3, 64'hFFFF_FFFF_FFFF_FFF5);
        // Only src_b[5:0] is the shift amount: 0x43 shifts by 3.
        alu_vec("sll_mask", ALU_OP_SLL,  64'd1, 64'h43, 64'd8);
        alu_vec("slt_pos", ALU_OP_SLT,   64'd3, NEG8, 64'd0);
        alu_vec("sltu_big", ALU_OP_SLTU, 64'd3, NEG8, 64'd1);

`ifdef ALU_OVF_EN
        alu_vec("add_max", ALU_OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000);
        check("ovf_add", {63'd0, alu_overflow}, 64'd1);
        alu_vec("sub_0m1", ALU_OP_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ovf_sub", {63'd0, alu_overflow}, 64'd0);
        alu_vec("sub_min", ALU_OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
                64'h7FFF_FFFF_FFFF_FFFF);
        check("ovf_sub_min", {63'd0, alu_overflow}, 64'd1);
        alu_vec("xor_max", ALU_OP_XOR, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                64'h7FFF_FFFF_FFFF_FFFE);
        check("ovf_other", {63'd0, alu_overflow}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
